uart_byte_tx: RTL and testbench
===============================

// Module: uart_byte_tx
// PURPOSE
//   Serialises bytes from the send-source stage onto the UART/Bluetooth TX line.
//   Accepts a one-cycle enable strobe with an 8-bit byte and emits an 8N1/8E1/8O1 frame.
//   The frame is sent LSB first at a parameterised baud rate.
//   A single holding register absorbs one strobe that arrives while a frame is in flight.
//   Sits between the byte source (upstream) and the TX pin or Bluetooth module RX (downstream).
// PARAMETERS
//   CLK_FREQ   50_000_000  system clock frequency, Hz
//   BAUD_RATE  115200      line rate, bit/s
//   PARITY     0           0 = none, 1 = odd, 2 = even
//   STOP_BITS  1           1 or 2 stop bits
//   (derived) BAUD_DIV = CLK_FREQ / BAUD_RATE, integer truncation; must be >= 2
// PORTS
//   sys_clk    in   1  system clock, rising edge
//   sys_rst_n  in   1  asynchronous active-low reset
//   enable     in   1  one-cycle strobe: din valid this cycle
//   din        in   8  byte to send, sampled only when enable = 1
//   tx         out  1  serial line, idle high (registered)
//   busy       out  1  1 while a frame is on the line or the holding register is full
//   overflow   out  1  one-cycle pulse: strobe dropped because the holding register was full
// BEHAVIOUR
//   Reset (async, immediate, also mid-frame)
//   - tx = 1, busy = 0, overflow = 0.
//   - FSM goes to IDLE; baud counter, bit counter, shifter and hold_valid are cleared.
//   FSM states: IDLE -> START -> DATA -> [PARITY if PARITY != 0] -> STOP -> IDLE or START
//   - Every non-IDLE state lasts BAUD_DIV clocks per bit.
//   - The baud counter runs 0..BAUD_DIV-1 and is reset on every bit boundary.
//   - DATA emits shifter[0] and shifts right each bit; bit counter 0..7.
//   - PARITY bit: even = ^data, odd = ~^data.
//   - STOP holds tx = 1 for STOP_BITS * BAUD_DIV clocks.
//   Latency
//   - enable at rising edge N in IDLE (hold empty) -> tx = 0 from edge N+1.
//   - Frame length F = BAUD_DIV * (10 + (PARITY != 0) + (STOP_BITS - 1)) clocks.
//   Accepting strobes
//   - IDLE: load din into the shifter, go to START.
//   - Not IDLE and hold empty: din -> hold register, hold_valid = 1.
//   - Not IDLE and hold full: drop din; overflow = 1 for exactly one cycle.
//     The hold register is unchanged.
//   End of the last stop-bit clock
//   - If hold_valid: hold -> shifter, clear hold_valid, go to START on the next clock.
//     This gives no idle gap between frames.
//   - Else: go to IDLE.
//   Simultaneous events at the end-of-frame clock
//   - hold full + enable: hold -> shifter and din -> hold. No overflow.
//   - hold empty + enable: din -> shifter directly, back-to-back START.
//   busy
//   - busy = (state != IDLE) | hold_valid, registered.
//   - Rises on edge N+1 after an accepting strobe.
//   - Falls on the same edge that tx returns to idle after the last stop bit.
//   din is ignored whenever enable = 0. X on din with enable = 0 must not propagate.
// TESTING (CLK_FREQ=1_000_000, BAUD_RATE=100_000 -> BAUD_DIV=10, PARITY=0, STOP_BITS=1 unless noted)
//   1. Reset, then enable + din=8'hAA in IDLE
//      -> tx = 0,0,1,0,1,0,1,0,1,1, each bit 10 clocks, starting at edge N+1.
//      -> busy high for 100 clocks. overflow never asserts.
//   2. PARITY=2, din=8'h07
//      -> data bits 1,1,1,0,0,0,0,0, then parity 1, then stop. Frame is 110 clocks.
//   3. 8'h55 strobed at clock 0, 8'h0F strobed at clock 30
//      -> two frames back-to-back, second start bit at clock 101. busy continuous for 200 clocks.
//   4. Three strobes (8'h01, 8'h02, 8'h03) within one frame
//      -> 8'h01 and 8'h02 are sent. overflow pulses once, on the third strobe. 8'h03 is never sent.
//   5. Strobe exactly on the last stop-bit clock with hold empty
//      -> next start bit follows with no idle cycle. No overflow.
//   6. Assert sys_rst_n = 0 mid DATA bit 4
//      -> tx = 1 and busy = 0 immediately.
//      -> after release, a new 8'hAA frame is correct per test 1.

Source files
------------

// File: rtl/uart_byte_tx.sv
// UART byte transmitter: 8N1/8E1/8O1 framing, LSB first, with a one-deep holding register.
// A strobe that arrives during a frame is parked and sent back-to-back. A strobe that finds the hold full is dropped.
module uart_byte_tx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       enable,
  input  logic [7:0] din,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W    = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY_BIT, STOP} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] baud_cnt, baud_next;
  logic [2:0]       bit_cnt, bit_next;
  logic [7:0]       shifter, shift_next;
  logic [7:0]       frame_data, data_next;
  logic [7:0]       hold_data, hold_next;
  logic             hold_valid, hold_valid_next;
  logic             tx_next, busy_next, ovf_next;
  logic             bit_end, frame_end;

  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign frame_end = (state == STOP) && bit_end && (bit_cnt == STOP_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shifter    <= '0;
      frame_data <= '0;
      hold_data  <= '0;
      hold_valid <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_next;
      baud_cnt   <= baud_next;
      bit_cnt    <= bit_next;
      shifter    <= shift_next;
      frame_data <= data_next;
      hold_data  <= hold_next;
      hold_valid <= hold_valid_next;
      tx         <= tx_next;
      busy       <= busy_next;
      overflow   <= ovf_next;
    end
  end

  always_comb begin
    state_next      = state;
    baud_next       = baud_cnt;
    bit_next        = bit_cnt;
    shift_next      = shifter;
    data_next       = frame_data;
    hold_next       = hold_data;
    hold_valid_next = hold_valid;
    ovf_next        = 1'b0;
    tx_next         = 1'b1;
    busy_next       = 1'b0;

    if (state != IDLE) begin
      baud_next = bit_end ? '0 : baud_cnt + CNT_W'(1);
    end

    case (state)
      IDLE: begin
        if (enable) begin
          shift_next = din;
          data_next  = din;
          state_next = START;
          baud_next  = '0;
          bit_next   = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          bit_next   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_next = {1'b0, shifter[7:1]};
          if (bit_cnt == 3'd7) begin
            state_next = (PARITY != 0) ? PARITY_BIT : STOP;
            bit_next   = '0;
          end else begin
            bit_next = bit_cnt + 3'd1;
          end
        end
      end
      PARITY_BIT: begin
        if (bit_end) begin
          state_next = STOP;
          bit_next   = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          bit_next = bit_cnt + 3'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    // The end-of-frame clock reloads from the hold (or din) so the next start bit follows with no gap.
    if (frame_end) begin
      bit_next = '0;
      if (hold_valid) begin
        shift_next = hold_data;
        data_next  = hold_data;
        state_next = START;
        if (enable) begin
          hold_next = din;
        end else begin
          hold_valid_next = 1'b0;
        end
      end else if (enable) begin
        shift_next = din;
        data_next  = din;
        state_next = START;
      end else begin
        state_next = IDLE;
      end
    end else if (state != IDLE && enable) begin
      if (hold_valid) begin
        ovf_next = 1'b1;
      end else begin
        hold_next       = din;
        hold_valid_next = 1'b1;
      end
    end

    case (state_next)
      START:      tx_next = 1'b0;
      DATA:       tx_next = shift_next[0];
      PARITY_BIT: tx_next = (PARITY == 1) ? ~^data_next : ^data_next;
      default:    tx_next = 1'b1;
    endcase
    busy_next = (state_next != IDLE) | hold_valid_next;
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Testbench for uart_byte_tx: frame tables, hand-written hold/overflow/reset sequences,
// and random strobes compared cycle by cycle against a frame-queue model.
module tb_uart_byte_tx;

  localparam int CLK_FREQ  = 1_000_000;
  localparam int BAUD_RATE = 100_000;
  localparam int BAUD_DIV  = 10;
  localparam int PARITY    = 0;
  localparam int STOP_BITS = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] din = '0;
  logic       tx, busy, overflow;
  logic       enable_p = 1'b0;
  logic [7:0] din_p = '0;
  logic       tx_p, busy_p, overflow_p;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  logic       exp_tx = 1'b1;
  logic       exp_busy = 1'b0;
  logic       exp_ovf = 1'b0;
  bit         line_q[$];
  bit         hold_full = 1'b0;
  logic [7:0] hold_byte = '0;

  logic tx_log[400];
  logic busy_log[400];
  logic ovf_log[400];

  typedef struct {
    bit         sel;
    logic [7:0] data;
    logic [0:10] bits;
    int         nbits;
  } vec_t;
  vec_t vecs[9];

  uart_byte_tx #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .PARITY(PARITY), .STOP_BITS(STOP_BITS)
  ) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .enable(enable), .din(din),
    .tx(tx), .busy(busy), .overflow(overflow)
  );

  uart_byte_tx #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .PARITY(2), .STOP_BITS(1)
  ) dut_par (
    .sys_clk(clk), .sys_rst_n(rst_n), .enable(enable_p), .din(din_p),
    .tx(tx_p), .busy(busy_p), .overflow(overflow_p)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void push_frame(input logic [7:0] b);
    bit frame[$];
    frame.push_back(1'b0);
    for (int i = 0; i < 8; i++) frame.push_back(b[i]);
    if (PARITY != 0) frame.push_back((PARITY == 2) ? ^b : ~^b);
    for (int s = 0; s < STOP_BITS; s++) frame.push_back(1'b1);
    foreach (frame[i]) begin
      for (int k = 0; k < BAUD_DIV; k++) line_q.push_back(frame[i]);
    end
  endfunction

  // Reference: the line is a queue of per-clock levels; an empty queue marks a frame boundary.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q.delete();
      hold_full = 1'b0;
      exp_tx    = 1'b1;
      exp_busy  = 1'b0;
      exp_ovf   = 1'b0;
    end else begin
      exp_ovf = 1'b0;
      if (line_q.size() == 0) begin
        if (hold_full) begin
          push_frame(hold_byte);
          if (enable) hold_byte = din;
          else hold_full = 1'b0;
        end else if (enable) begin
          push_frame(din);
        end
      end else if (enable) begin
        if (hold_full) exp_ovf = 1'b1;
        else begin
          hold_full = 1'b1;
          hold_byte = din;
        end
      end
      if (line_q.size() != 0) begin
        exp_tx   = line_q.pop_front();
        exp_busy = 1'b1;
      end else begin
        exp_tx   = 1'b1;
        exp_busy = hold_full;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on && rst_n) begin
      check_output("model_tx", tx, exp_tx);
      check_output("model_busy", busy, exp_busy);
      check_output("model_overflow", overflow, exp_ovf);
    end
  end

  task automatic apply_stimulus(input bit sel, input logic [7:0] d);
    @(negedge clk);
    if (sel) begin enable_p = 1'b1; din_p = d; end
    else begin enable = 1'b1; din = d; end
    @(negedge clk);
    enable = 1'b0; din = 'x; enable_p = 1'b0; din_p = 'x;
  endtask

  task automatic check_frame(input int idx);
    int   busy_cycles = 0;
    int   ovf_cycles = 0;
    int   len;
    logic cur_tx, cur_busy, cur_ovf;
    len = vecs[idx].nbits * BAUD_DIV;
    for (int c = 0; c <= len + 4; c++) begin
      if (c > 0) @(negedge clk);
      cur_tx   = vecs[idx].sel ? tx_p : tx;
      cur_busy = vecs[idx].sel ? busy_p : busy;
      cur_ovf  = vecs[idx].sel ? overflow_p : overflow;
      if (cur_busy) busy_cycles++;
      if (cur_ovf) ovf_cycles++;
      if (c == 0) check_output($sformatf("vec%0d_start_latency", idx), cur_tx, 1'b0);
      if (c < len && (c % BAUD_DIV) == BAUD_DIV / 2)
        check_output($sformatf("vec%0d_bit%0d", idx, c / BAUD_DIV), cur_tx, vecs[idx].bits[c / BAUD_DIV]);
      if (c == len + 4) check_output($sformatf("vec%0d_idle_tx", idx), cur_tx, 1'b1);
    end
    check_output($sformatf("vec%0d_busy_len", idx), busy_cycles, len);
    check_output($sformatf("vec%0d_overflow_cnt", idx), ovf_cycles, 0);
  endtask

  task automatic run_window(input int len, input int at1, input logic [7:0] d1,
                            input int at2, input logic [7:0] d2,
                            output int busy_cycles, output int ovf_cycles);
    busy_cycles = 0;
    ovf_cycles  = 0;
    for (int c = 0; c < len; c++) begin
      if (c > 0) @(negedge clk);
      tx_log[c]   = tx;
      busy_log[c] = busy;
      ovf_log[c]  = overflow;
      if (busy) busy_cycles++;
      if (overflow) ovf_cycles++;
      if (c == at1) begin enable = 1'b1; din = d1; end
      else if (c == at2) begin enable = 1'b1; din = d2; end
      else begin enable = 1'b0; din = 'x; end
    end
    @(negedge clk);
    enable = 1'b0; din = 'x;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int bc, oc;
    vecs[0] = '{1'b0, 8'hAA, {10'b0010101011, 1'b1}, 10};
    vecs[1] = '{1'b0, 8'h55, {10'b0101010101, 1'b1}, 10};
    vecs[2] = '{1'b0, 8'h0F, {10'b0111100001, 1'b1}, 10};
    vecs[3] = '{1'b0, 8'h80, {10'b0000000011, 1'b1}, 10};
    vecs[4] = '{1'b0, 8'h00, {10'b0000000001, 1'b1}, 10};
    vecs[5] = '{1'b0, 8'hFF, {10'b0111111111, 1'b1}, 10};
    vecs[6] = '{1'b1, 8'h07, 11'b01110000011, 11};
    vecs[7] = '{1'b1, 8'h03, 11'b01100000001, 11};
    vecs[8] = '{1'b1, 8'h80, 11'b00000000111, 11};

    repeat (3) @(negedge clk);
    check_output("reset_tx", tx, 1'b1);
    check_output("reset_busy", busy, 1'b0);
    check_output("reset_overflow", overflow, 1'b0);
    check_output("reset_tx_par", tx_p, 1'b1);
    rst_n  = 1'b1;
    chk_on = 1'b1;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 9; v++) begin
      apply_stimulus(vecs[v].sel, vecs[v].data);
      check_frame(v);
    end

    $display("[TB] back-to-back via hold register");
    apply_stimulus(1'b0, 8'h55);
    run_window(210, 29, 8'h0F, -1, 8'h00, bc, oc);
    check_output("b2b_last_stop", tx_log[99], 1'b1);
    check_output("b2b_second_start", tx_log[100], 1'b0);
    check_output("b2b_second_bit0", tx_log[115], 1'b1);
    check_output("b2b_second_bit4", tx_log[155], 1'b0);
    check_output("b2b_busy_len", bc, 200);
    check_output("b2b_busy_after", busy_log[200], 1'b0);
    check_output("b2b_overflow_cnt", oc, 0);

    $display("[TB] three strobes in one frame");
    apply_stimulus(1'b0, 8'h01);
    run_window(220, 20, 8'h02, 40, 8'h03, bc, oc);
    check_output("ovf_pulse_cnt", oc, 1);
    check_output("ovf_pulse_time", ovf_log[41], 1'b1);
    check_output("ovf_second_bit0", tx_log[115], 1'b0);
    check_output("ovf_second_bit1", tx_log[125], 1'b1);
    check_output("ovf_busy_len", bc, 200);
    check_output("ovf_idle_after", tx_log[205], 1'b1);

    $display("[TB] strobe on last stop clock, hold empty");
    apply_stimulus(1'b0, 8'hAA);
    run_window(210, 99, 8'h0F, -1, 8'h00, bc, oc);
    check_output("edge_last_stop", tx_log[99], 1'b1);
    check_output("edge_next_start", tx_log[100], 1'b0);
    check_output("edge_busy_kept", busy_log[100], 1'b1);
    check_output("edge_overflow_cnt", oc, 0);
    check_output("edge_busy_len", bc, 200);

    $display("[TB] strobe on last stop clock, hold full");
    apply_stimulus(1'b0, 8'h01);
    run_window(310, 30, 8'h02, 99, 8'h03, bc, oc);
    check_output("holdfull_overflow_cnt", oc, 0);
    check_output("holdfull_second_bit0", tx_log[115], 1'b0);
    check_output("holdfull_third_start", tx_log[200], 1'b0);
    check_output("holdfull_third_bit0", tx_log[215], 1'b1);
    check_output("holdfull_third_bit1", tx_log[225], 1'b1);
    check_output("holdfull_busy_len", bc, 300);

    $display("[TB] reset during data bit 4");
    apply_stimulus(1'b0, 8'hAA);
    repeat (55) @(negedge clk);
    check_output("midrst_before_tx", tx, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_output("midrst_tx", tx, 1'b1);
    check_output("midrst_busy", busy, 1'b0);
    check_output("midrst_overflow", overflow, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    apply_stimulus(1'b0, vecs[0].data);
    check_frame(0);

    $display("[TB] random strobes against model");
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 24) == 0) begin
        enable = 1'b1;
        din    = 8'($urandom);
      end else begin
        enable = 1'b0;
        din    = 'x;
      end
    end
    @(negedge clk);
    enable = 1'b0;
    din    = 'x;
    repeat (250) @(negedge clk);
    check_output("random_drain_busy", busy, 1'b0);
    check_output("random_drain_tx", tx, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
